// File: rtl/fft_frame_ctrl.sv
// Frame controller in front of an SDF FFT pipeline: frames input samples,
// tracks frames in flight, forwards pipeline output and flushes on errors.
module fft_frame_ctrl #(
  parameter int N            = 128,
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 2,
  parameter int FLUSH_CYC    = 3*N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_on,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  input  logic             s_last,
  output logic             fft_on,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             m_last,
  output logic             busy,
  output logic             err_underrun,
  output logic             err_len
);

  // state | meaning
  // IDLE  | waiting for the first sample of a frame
  // RUN   | frame in progress, one sample per cycle expected
  // GAP   | single idle cycle between frames (di_en low)
  // ABORT | pipeline held off for FLUSH_CYC cycles, in-flight frames dropped

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] LAST_IDX   = CW'(N - 1);
  localparam logic [1:0]    MAX_IF     = 2'(MAX_INFLIGHT);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP,
    ST_ABORT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_in_cnt;
  logic [CW-1:0]     r_out_cnt;
  logic [1:0]        r_inflight;
  logic [FW-1:0]     r_flush;
  logic              r_di_en;
  logic [WIDTH-1:0]  r_di_re;
  logic [WIDTH-1:0]  r_di_im;
  logic              r_m_valid;
  logic              r_m_last;
  logic [WIDTH-1:0]  r_m_re;
  logic [WIDTH-1:0]  r_m_im;
  logic              r_err_len;
  logic              r_err_und;

  logic              w_s_ready;
  logic              w_hs;
  logic              w_frame_end;
  logic              w_err_len;
  logic              w_err_und;
  logic              w_abort;
  logic              w_out_acc;
  logic              w_out_last;

  // Ready is held low while reset is applied so no handshake can slip through.
  assign w_s_ready = rst & ((r_state == ST_RUN) |
                            ((r_state == ST_IDLE) & cfg_on & (r_inflight < MAX_IF)));
  assign w_hs      = s_valid & w_s_ready;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_end = 1'b0;
    w_err_len   = 1'b0;
    w_err_und   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hs) begin
          if (s_last) begin
            w_err_len   = 1'b1;
            w_state_nxt = ST_ABORT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!w_hs) begin
          w_err_und   = 1'b1;
          w_state_nxt = ST_ABORT;
        end else if (r_in_cnt == LAST_IDX) begin
          if (s_last) begin
            w_frame_end = 1'b1;
            w_state_nxt = ST_GAP;
          end else begin
            w_err_len   = 1'b1;
            w_state_nxt = ST_ABORT;
          end
        end else if (s_last) begin
          w_err_len   = 1'b1;
          w_state_nxt = ST_ABORT;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        if (r_flush == '0) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_abort = (w_state_nxt == ST_ABORT) && (r_state != ST_ABORT);

  // Output is dropped in ABORT and in the cycle entering it, and when nothing is owed.
  assign w_out_acc  = fft_do_en && (r_state != ST_ABORT) && (w_state_nxt != ST_ABORT) &&
                      !((r_inflight == 2'd0) && (r_out_cnt == '0));
  assign w_out_last = w_out_acc && (r_out_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_in_cnt   <= '0;
      r_out_cnt  <= '0;
      r_inflight <= 2'd0;
      r_flush    <= '0;
      r_di_en    <= 1'b0;
      r_di_re    <= '0;
      r_di_im    <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_re     <= '0;
      r_m_im     <= '0;
      r_err_len  <= 1'b0;
      r_err_und  <= 1'b0;
    end else begin
      r_di_en   <= w_hs;
      r_m_valid <= w_out_acc;
      r_m_last  <= w_out_last;
      r_err_len <= w_err_len;
      r_err_und <= w_err_und;
      if (w_hs) begin
        r_di_re <= s_re;
        r_di_im <= s_im;
      end
      if (w_out_acc) begin
        r_m_re <= fft_do_re;
        r_m_im <= fft_do_im;
      end
      if (w_abort) begin
        r_in_cnt   <= '0;
        r_out_cnt  <= '0;
        r_inflight <= 2'd0;
        r_flush    <= FLUSH_LOAD;
      end else begin
        if ((r_state == ST_ABORT) && (r_flush != '0)) r_flush <= r_flush - FW'(1);
        if (w_hs) r_in_cnt <= w_frame_end ? '0 : r_in_cnt + CW'(1);
        if (w_out_acc) r_out_cnt <= r_out_cnt + CW'(1);
        if (w_frame_end && !w_out_last)      r_inflight <= r_inflight + 2'd1;
        else if (!w_frame_end && w_out_last) r_inflight <= r_inflight - 2'd1;
      end
    end
  end

  assign s_ready      = w_s_ready;
  assign fft_on       = (r_state != ST_ABORT);
  assign fft_di_en    = r_di_en;
  assign fft_di_re    = r_di_re;
  assign fft_di_im    = r_di_im;
  assign m_valid      = r_m_valid;
  assign m_last       = r_m_last;
  assign m_re         = r_m_re;
  assign m_im         = r_m_im;
  assign busy         = (r_state != ST_IDLE) || (r_inflight != 2'd0);
  assign err_underrun = r_err_und;
  assign err_len      = r_err_len;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: stimulus queues expected pipeline input,
// forwarded output and error pulses; a negedge monitor pops and compares them.
module tb_fft_frame_ctrl;
  localparam int N     = 128;
  localparam int W     = 16;
  localparam int MAXF  = 2;
  localparam int FLUSH = 3*N;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_on;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_re, s_im;
  logic         s_last;
  logic         fft_on;
  logic         fft_di_en;
  logic [W-1:0] fft_di_re, fft_di_im;
  logic         fft_do_en;
  logic [W-1:0] fft_do_re, fft_do_im;
  logic         m_valid;
  logic [W-1:0] m_re, m_im;
  logic         m_last;
  logic         busy;
  logic         err_underrun;
  logic         err_len;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N(N), .WIDTH(W), .MAX_INFLIGHT(MAXF), .FLUSH_CYC(FLUSH)) dut (
    .clk(clk), .rst(rst), .cfg_on(cfg_on),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .fft_on(fft_on), .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .busy(busy), .err_underrun(err_underrun), .err_len(err_len)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] q_di[$];
  logic [32:0] q_m[$];
  int          q_err[$];
  logic [31:0] e_di;
  logic [32:0] e_m;
  int          e_err;
  int          w4, w6, wx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] di_word(input int tag, input int idx);
    logic [15:0] re;
    re = {tag[7:0], idx[7:0]};
    return {re, ~re};
  endfunction

  function automatic logic [31:0] do_word(input int tag, input int idx);
    logic [15:0] re;
    re = {1'b1, tag[6:0], idx[7:0]};
    return {re, re ^ 16'h5A5A};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (fft_di_en === 1'b1) begin
        n_checks++;
        if (q_di.size() == 0) begin
          n_fail++;
          $display("FAIL di_unexpected: got %h with nothing expected", {fft_di_re, fft_di_im});
        end else begin
          e_di = q_di.pop_front();
          if ({fft_di_re, fft_di_im} !== e_di) begin
            n_fail++;
            $display("FAIL di_data: got %h expected %h", {fft_di_re, fft_di_im}, e_di);
          end
        end
      end
      if (m_valid === 1'b1) begin
        n_checks++;
        if (q_m.size() == 0) begin
          n_fail++;
          $display("FAIL m_unexpected: got last=%b %h with nothing expected", m_last, {m_re, m_im});
        end else begin
          e_m = q_m.pop_front();
          if ({m_last, m_re, m_im} !== e_m) begin
            n_fail++;
            $display("FAIL m_data: got %h expected %h", {m_last, m_re, m_im}, e_m);
          end
        end
      end
      if (err_underrun === 1'b1 || err_len === 1'b1) begin
        n_checks++;
        if (q_err.size() == 0) begin
          n_fail++;
          $display("FAIL err_unexpected: got und=%b len=%b with nothing expected", err_underrun, err_len);
        end else begin
          e_err = q_err.pop_front();
          if ({err_len, err_underrun} !== 2'(e_err)) begin
            n_fail++;
            $display("FAIL err_kind: got len/und=%b%b expected code %0d", err_len, err_underrun, e_err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget, output int waited, output bit ok);
    waited = 0;
    while (!s_ready && waited < budget) begin
      tick();
      waited++;
    end
    ok = s_ready;
  endtask

  task automatic send_frame(input int tag, input int len, input int last_idx, input int drop_at,
                            input int rst_at, input int cfg_off_at, output int waited);
    bit          ok;
    logic [31:0] w;
    w = di_word(tag, 0);
    {s_re, s_im} = w;
    s_last  = (last_idx == 0);
    s_valid = 1'b1;
    wait_ready(400, waited, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_start tag %0d: s_ready %b after %0d cycles, required 1", tag, s_ready, waited);
      s_valid = 1'b0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      w = di_word(tag, i);
      if (i == drop_at) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        q_err.push_back(1);
        tick();
        return;
      end
      if (i == rst_at) begin
        {s_re, s_im} = w;
        rst = 1'b0;
        tick();
        return;
      end
      if (i == cfg_off_at) cfg_on = 1'b0;
      {s_re, s_im} = w;
      s_last  = (i == last_idx);
      s_valid = 1'b1;
      q_di.push_back(w);
      if ((i == last_idx && i != N-1) || (i == N-1 && last_idx != N-1)) q_err.push_back(2);
      tick();
      if (i == 0) begin
        chk("di_first_en", fft_di_en, 1);
        chk("di_first_re", fft_di_re, w[31:16]);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic emit_frame(input int tag, input bit expect_out);
    logic [31:0] w;
    for (int i = 0; i < N; i++) begin
      w = do_word(tag, i);
      fft_do_en = 1'b1;
      {fft_do_re, fft_do_im} = w;
      if (expect_out) q_m.push_back({(i == N-1), w});
      tick();
    end
    fft_do_en = 1'b0;
  endtask

  task automatic check_abort(input string name, input bit drive_do);
    int          lowc;
    int          mv;
    logic [31:0] w;
    lowc = 0;
    mv   = 0;
    w    = do_word(77, 5);
    fft_do_en = drive_do;
    {fft_do_re, fft_do_im} = w;
    while (fft_on === 1'b0 && lowc < FLUSH + 50) begin
      if (m_valid !== 1'b0) mv++;
      tick();
      lowc++;
    end
    fft_do_en = 1'b0;
    chk({name, "_len"}, lowc, FLUSH);
    chk({name, "_mvalid"}, mv, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_s_ready"}, s_ready, 0);
    chk({name, "_di_en"}, fft_di_en, 0);
    chk({name, "_m_valid"}, m_valid, 0);
    chk({name, "_m_last"}, m_last, 0);
    chk({name, "_err_und"}, err_underrun, 0);
    chk({name, "_err_len"}, err_len, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_fft_on"}, fft_on, 1);
    chk({name, "_di_data"}, {fft_di_re, fft_di_im}, 0);
    chk({name, "_m_data"}, {m_re, m_im}, 0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_on = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0;
    fft_do_en = 1'b0; fft_do_re = '0; fft_do_im = '0;
    tick();
    tick();
    mon_en = 1'b1;
    s_valid = 1'b1;
    #1;
    check_reset_vals("por");
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("idle_ready", s_ready, 1);

    // Output with nothing owed must not be forwarded.
    fft_do_en = 1'b1;
    repeat (3) tick();
    fft_do_en = 1'b0;
    tick();
    chk("spurious_busy", busy, 0);

    // Single frame.
    send_frame(1, N, N-1, -1, -1, -1, wx);
    chk("gap_ready", s_ready, 0);
    chk("gap_busy", busy, 1);
    chk("gap_fft_on", fft_on, 1);
    tick();
    chk("gap_di_en", fft_di_en, 0);
    chk("inflight1_busy", busy, 1);
    emit_frame(1, 1'b1);
    chk("single_done_busy", busy, 0);

    // Back-to-back with MAX_INFLIGHT=2; cfg_on dropped mid frame 4.
    send_frame(2, N, N-1, -1, -1, -1, wx);
    send_frame(3, N, N-1, -1, -1, -1, wx);
    chk("b2b_gap_wait", wx, 1);
    fork
      emit_frame(2, 1'b1);
      send_frame(4, N, N-1, -1, -1, 10, w4);
    join
    chk("b2b_third_wait", w4, N);
    emit_frame(3, 1'b1);
    emit_frame(4, 1'b1);
    chk("cfg_off_busy", busy, 0);
    chk("cfg_off_ready", s_ready, 0);
    cfg_on = 1'b1;
    #1;
    chk("cfg_on_ready", s_ready, 1);

    // Frame end coincident with m_last of the previous frame.
    send_frame(5, N, N-1, -1, -1, -1, wx);
    tick();
    fork
      emit_frame(5, 1'b1);
      send_frame(6, N, N-1, -1, -1, -1, w6);
    join
    chk("coinc_align", w6, 0);
    tick();
    chk("coinc_inflight_busy", busy, 1);
    emit_frame(6, 1'b1);
    chk("coinc_drain_busy", busy, 0);

    // Underrun at sample 50 with one frame in flight; that frame is discarded.
    send_frame(7, N, N-1, -1, -1, -1, wx);
    tick();
    send_frame(8, N, N-1, 50, -1, -1, wx);
    chk("underrun_fft_on", fft_on, 0);
    check_abort("underrun", 1'b1);
    chk("underrun_idle_ready", s_ready, 1);
    emit_frame(7, 1'b0);

    // Length errors: early s_last, then missing s_last.
    send_frame(9, 100, 99, -1, -1, -1, wx);
    check_abort("len_early", 1'b0);
    send_frame(10, N, -1, -1, -1, -1, wx);
    check_abort("len_nolast", 1'b0);

    // Reset at sample 60 with a frame in flight, then a fresh frame.
    send_frame(11, N, N-1, -1, -1, -1, wx);
    tick();
    send_frame(12, N, N-1, -1, 60, -1, wx);
    check_reset_vals("midrst");
    rst = 1'b1;
    s_valid = 1'b0;
    tick();
    send_frame(13, N, N-1, -1, -1, -1, wx);
    tick();
    chk("fresh_busy_inflight", busy, 1);
    emit_frame(13, 1'b1);
    chk("fresh_done_busy", busy, 0);

    repeat (3) tick();
    chk("q_di_empty", q_di.size(), 0);
    chk("q_m_empty", q_m.size(), 0);
    chk("q_err_empty", q_err.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 128, meaning FFT points per frame (power of two, 8..1024).
REQ-002 SHALL have parameter WIDTH, default 16, meaning sample component width.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 2, meaning maximum accepted-but-not-emitted frames (1..3).
REQ-004 SHALL have parameter FLUSH_CYC, default 3*N, meaning cycles `fft_on` is held low after an abort.
REQ-005 SHALL have the ports, listed as name, direction, width, meaning:
- clk  in  1  master clock; one clock domain only.
- rst  in  1  reset; synchronous, active-low.
- cfg_on  in  1  enables acceptance of new frames.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample ready.
- s_re, s_im  in  WIDTH  input sample.
- s_last  in  1  last sample of input frame.
- fft_on  out  1  drives the SDF pipeline `on`.
- fft_di_en  out  1  drives the SDF pipeline `di_en`.
- fft_di_re, fft_di_im  out  WIDTH  drive the SDF pipeline data inputs.
- fft_do_en  in  1  SDF pipeline output enable.
- fft_do_re, fft_do_im  in  WIDTH  SDF pipeline output data.
- m_valid  out  1  output sample valid (no backpressure).
- m_re, m_im  out  WIDTH  output sample.
- m_last  out  1  last output sample of frame.
- busy  out  1  state != IDLE or inflight != 0.
- err_underrun  out  1  one-cycle pulse: `s_valid` low mid-frame.
- err_len  out  1  one-cycle pulse: `s_last` at wrong position.

Function
REQ-006 SHALL implement states IDLE, RUN, GAP and ABORT, plus an in-count (log2 N bits), an out-count (log2 N bits) and an inflight counter (2 bits).
REQ-007 SHALL drive `s_ready`=1 in IDLE only when `cfg_on`=1 and inflight<MAX_INFLIGHT; in RUN, `s_ready`=1; in GAP and ABORT, `s_ready`=0.
REQ-008 SHALL, in IDLE, move to RUN on a handshake (s_valid&s_ready), with in-count=1.
REQ-009 SHALL register every accepted sample onto `fft_di_re`/`fft_di_im` with `fft_di_en`=1, exactly one cycle after the handshake.
REQ-010 SHALL hold `fft_di_en`=0 in any cycle following a non-handshake cycle.
REQ-011 SHALL increment in-count per handshake in RUN; in-count wraps to 0 after N-1.
REQ-012 SHALL, on a handshake with in-count==N-1 and `s_last`=1, go to GAP, increment inflight and reset in-count to 0.
REQ-013 SHALL stay in GAP for exactly one cycle, then return to IDLE, which guarantees `fft_di_en` low for at least one cycle between frames.
REQ-014 SHALL, on `s_last`=1 with in-count!=N-1, pulse `err_len` and go to ABORT.
REQ-015 SHALL, on in-count==N-1 with `s_last`=0, pulse `err_len` and go to ABORT.
REQ-016 SHALL, on `s_valid`=0 in RUN, pulse `err_underrun` and go to ABORT; the sample is not consumed.
REQ-017 SHALL, in ABORT, drive `fft_on`=0 and `m_valid`=0 for FLUSH_CYC cycles, then go to IDLE.
REQ-018 SHALL clear inflight, out-count and in-count on ABORT entry, discarding all in-flight frames.
REQ-019 SHALL drive `fft_on`=1 in all states other than ABORT.
REQ-020 SHALL register each `fft_do_en`=1 sample, outside ABORT, to `m_valid`/`m_re`/`m_im` with a latency of 1 cycle.
REQ-021 SHALL increment out-count on each such sample.
REQ-022 SHALL assert `m_last`=1 with `m_valid` when out-count==N-1; out-count then wraps to 0 and inflight decrements.
REQ-023 SHALL leave inflight unchanged when a same-cycle increment (REQ-012) and decrement (REQ-022) coincide.
REQ-024 SHALL ignore `fft_do_en` when inflight==0 and out-count==0 (spurious output, not forwarded).
REQ-025 SHALL, on `cfg_on` falling mid-frame, complete the current frame; only new frames are blocked.

Reset
REQ-026 SHALL, with rst=0 at a clock edge, set state=IDLE and clear all counters.
REQ-027 SHALL reset `s_ready`, `fft_di_en`, `m_valid`, `m_last`, `err_underrun`, `err_len` and `busy` to 0, and `fft_on` to 1.
REQ-028 SHALL reset data outputs to 0.
REQ-029 SHALL give reset priority over all events, including a mid-frame reset.

Verification
REQ-030 Single frame: N=128, 128 contiguous samples with s_last on the 128th -> 128 cycles of fft_di_en=1 delayed by 1, then one gap cycle, inflight=1; 128 fft_do_en pulses -> 128 m_valid with m_last on the 128th, inflight=0, busy=0.
REQ-031 Back-to-back: 3 frames offered, MAX_INFLIGHT=2 -> third frame's s_ready held 0 until first m_last, then accepted.
REQ-032 Underrun: s_valid dropped at sample 50 -> err_underrun one pulse, fft_on=0 for 384 cycles, m_valid=0 throughout, then IDLE.
REQ-033 Length error: s_last on sample 100 -> err_len pulse and ABORT; separately, no s_last at sample 128 -> err_len pulse.
REQ-034 Coincident: frame-end handshake in the same cycle as m_last -> inflight unchanged.
REQ-035 Reset: rst=0 at sample 60 -> next cycle all outputs at reset values; a fresh frame afterwards completes correctly.
